// File: rtl/star_field_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | star_field_gen : LFSR star field with night fade and twinkle modes    |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
module star_field_gen #(
  parameter int          XW         = 10,
  parameter int          YW         = 9,
  parameter int          COLRW      = 12,
  parameter int          SKY_H      = 120,
  parameter int          DENSITY    = 8,
  parameter logic [15:0] SEED       = 16'hACE1,
  parameter int          NIGHT_STEP = 16,
  parameter int          TW_BIT     = 4
) (
  input  logic             clk_pix,
  input  logic             rst_n,
  input  logic             frame,
  input  logic             de,
  input  logic [XW-1:0]    sx,
  input  logic [YW-1:0]    sy,
  input  logic [7:0]       fade_level,
  input  logic [1:0]       mode,
  output logic [COLRW-1:0] star_colr,
  output logic             star_valid
);

  localparam int          CW           = COLRW / 3;
  localparam logic [15:0] c_lfsr_mask  = 16'hB400;
  localparam logic [YW-1:0] c_sky_h    = YW'(SKY_H);
  localparam logic [7:0]  c_night_step = 8'(NIGHT_STEP);
  localparam logic [1:0]  c_mode_off   = 2'd0;
  localparam logic [1:0]  c_mode_steady = 2'd1;
  localparam logic [1:0]  c_mode_twinkle = 2'd2;

  logic [15:0] lfsr_q, lfsr_d, lfsr_step;
  logic [7:0]  frame_cnt_q, frame_cnt_d;
  logic [7:0]  night_q, night_d;
  logic [8:0]  night_up;
  logic        sky, night_tgt_hi, twinkle;

  logic        s1_hit_q, s1_hit_d;
  logic        s1_lit_q, s1_lit_d;
  logic        s1_dim_q, s1_dim_d;
  logic [7:0]  s1_base_q, s1_base_d;
  logic [7:0]  s1_night_q, s1_night_d;

  logic [7:0]  eff;
  logic [15:0] product;
  logic [7:0]  s2_scaled_q, s2_scaled_d;
  logic [CW-1:0] chan;
  logic        unused_ok;

  always_comb begin
    sky       = de && (sy < c_sky_h);
    lfsr_step = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? c_lfsr_mask : 16'h0000);

    lfsr_d = lfsr_q;
    if (frame) begin
      lfsr_d = SEED;
    end else if (sky) begin
      lfsr_d = lfsr_step;
    end

    frame_cnt_d = frame ? frame_cnt_q + 8'd1 : frame_cnt_q;

    // Night ramps toward full dark outside the daytime fade window.
    night_tgt_hi = (fade_level < 8'd64) || (fade_level > 8'd208);
    night_up     = {1'b0, night_q} + {1'b0, c_night_step};
    night_d      = night_q;
    if (frame) begin
      if (night_tgt_hi) begin
        night_d = night_up[8] ? 8'hFF : night_up[7:0];
      end else begin
        night_d = (night_q < c_night_step) ? 8'h00 : night_q - c_night_step;
      end
    end
  end

  // Stage 1 samples the pre-advance LFSR and pre-pulse frame state.
  always_comb begin
    s1_hit_d   = sky && (&lfsr_q[15 -: DENSITY]);
    s1_base_d  = lfsr_q[7:0] | 8'h80;
    s1_night_d = night_q;
    twinkle    = frame_cnt_q[TW_BIT] ^ lfsr_q[8];
    s1_lit_d   = 1'b0;
    s1_dim_d   = 1'b0;
    case (mode)
      c_mode_off:     s1_lit_d = 1'b0;
      c_mode_steady:  s1_lit_d = 1'b1;
      c_mode_twinkle: s1_lit_d = twinkle;
      default: begin
        s1_lit_d = twinkle;
        s1_dim_d = 1'b1;
      end
    endcase
  end

  always_comb begin
    eff = 8'h00;
    if (s1_lit_q) begin
      eff = s1_base_q;
    end else if (s1_dim_q) begin
      eff = s1_base_q >> 2;
    end
    product     = 16'(eff) * 16'(s1_night_q);
    s2_scaled_d = s1_hit_q ? product[15:8] : 8'h00;
  end

  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q      <= SEED;
      frame_cnt_q <= 8'h00;
      night_q     <= 8'h00;
      s1_hit_q    <= 1'b0;
      s1_lit_q    <= 1'b0;
      s1_dim_q    <= 1'b0;
      s1_base_q   <= 8'h00;
      s1_night_q  <= 8'h00;
      s2_scaled_q <= 8'h00;
    end else begin
      lfsr_q      <= lfsr_d;
      frame_cnt_q <= frame_cnt_d;
      night_q     <= night_d;
      s1_hit_q    <= s1_hit_d;
      s1_lit_q    <= s1_lit_d;
      s1_dim_q    <= s1_dim_d;
      s1_base_q   <= s1_base_d;
      s1_night_q  <= s1_night_d;
      s2_scaled_q <= s2_scaled_d;
    end
  end

  assign chan       = s2_scaled_q[7 -: CW];
  assign star_colr  = {3{chan}};
  assign star_valid = |chan;

  // Horizontal position and most counter bits do not affect the pattern.
  assign unused_ok = ^{sx, frame_cnt_q};

endmodule
`default_nettype wire

// File: tb/tb_star_field_gen.sv
`default_nettype none
// tb_star_field_gen : directed bench with a reference LFSR/night model.
module tb_star_field_gen;

  localparam logic [15:0] SEED = 16'hACE1;
  localparam int W  = 80;
  localparam int HB = 4;

  logic        clk_pix = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame = 1'b0;
  logic        de = 1'b0;
  logic [9:0]  sx = '0;
  logic [8:0]  sy = '0;
  logic [7:0]  fade_level = 8'd0;
  logic [1:0]  mode = 2'd0;
  logic [11:0] star_colr;
  logic        star_valid;

  int total = 0;
  int bad = 0;

  logic [15:0] m_lfsr;
  logic [7:0]  m_night;
  logic [7:0]  m_fcnt;
  logic [11:0] exp_colr_d;
  logic        exp_valid_d;
  int          vcount, hcount;

  always #5 clk_pix = ~clk_pix;

  star_field_gen dut (
    .clk_pix(clk_pix), .rst_n(rst_n), .frame(frame), .de(de),
    .sx(sx), .sy(sy), .fade_level(fade_level), .mode(mode),
    .star_colr(star_colr), .star_valid(star_valid)
  );

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_lfsr = SEED; m_night = 8'd0; m_fcnt = 8'd0;
    exp_colr_d = 12'd0; exp_valid_d = 1'b0;
  endtask

  // One pixel clock: drive, predict, clock, check output of previous step.
  task automatic step(input logic f, input logic d, input int x, input int y);
    logic elig, hit, lit;
    logic [7:0] base, eff;
    logic [15:0] prod;
    logic [3:0] ch;
    logic [11:0] ec;
    logic ev;
    int n;
    frame = f; de = d; sx = 10'(x); sy = 9'(y);
    elig = d && (y < 120);
    hit  = elig && (m_lfsr[15:8] == 8'hFF);
    base = m_lfsr[7:0] | 8'h80;
    lit  = (mode == 2'd1) || ((mode >= 2'd2) && (m_fcnt[4] ^ m_lfsr[8]));
    if (lit) eff = base;
    else if (mode == 2'd3) eff = base >> 2;
    else eff = 8'd0;
    prod = 16'(eff) * 16'(m_night);
    ch   = hit ? prod[15:12] : 4'h0;
    ec   = {ch, ch, ch};
    ev   = (ch != 4'h0);
    if (hit) hcount++;
    @(posedge clk_pix); #1;
    chk("pix_colr", 32'(star_colr), 32'(exp_colr_d));
    chk("pix_valid", 32'(star_valid), 32'(exp_valid_d));
    if (star_valid) vcount++;
    exp_colr_d = ec; exp_valid_d = ev;
    if (f) begin
      m_lfsr = SEED;
      m_fcnt = m_fcnt + 8'd1;
      n = int'(m_night);
      if (fade_level < 8'd64 || fade_level > 8'd208) n = (n + 16 > 255) ? 255 : n + 16;
      else n = (n - 16 < 0) ? 0 : n - 16;
      m_night = 8'(n);
    end else if (elig) begin
      m_lfsr = lfsr_next(m_lfsr);
    end
  endtask

  task automatic scan(input int y0, input int y1, input int gap_row);
    for (int y = y0; y <= y1; y++) begin
      for (int x = 0; x < W; x++) begin
        if (y == gap_row && x == W / 2) begin
          for (int g = 0; g < 10; g++) begin
            step(1'b0, 1'b0, x, y);
            chk("gap_hold", 32'(dut.lfsr_q), 32'(m_lfsr));
          end
        end
        step(1'b0, 1'b1, x, y);
      end
      for (int b = 0; b < HB; b++) step(1'b0, 1'b0, 0, y);
    end
    step(1'b0, 1'b0, 0, 300);
    step(1'b0, 1'b0, 0, 300);
  endtask

  initial begin : main
    int va, na;
    logic found;
    model_reset();
    repeat (3) @(posedge clk_pix);
    #1;
    chk("rst_colr", 32'(star_colr), 32'd0);
    chk("rst_valid", 32'(star_valid), 32'd0);
    chk("rst_lfsr", 32'(dut.lfsr_q), 32'(SEED));
    chk("rst_night", 32'(dut.night_q), 32'd0);
    chk("rst_fcnt", 32'(dut.frame_cnt_q), 32'd0);
    rst_n = 1'b1;

    mode = 2'd1; fade_level = 8'd0;
    for (int k = 1; k <= 17; k++) begin
      step(1'b1, 1'b0, 0, 0);
      chk("night_ramp", 32'(dut.night_q), (16 * k > 255) ? 32'd255 : 32'(16 * k));
    end
    chk("fcnt17", 32'(dut.frame_cnt_q), 32'd17);

    // Steady frame covering off-sky rows, with a de gap mid-row.
    step(1'b1, 1'b0, 0, 0);
    scan(0, 129, 3);

    // Twinkle: frame_cnt 19 (bit4=1) then 35 (bit4=0).
    mode = 2'd2;
    step(1'b1, 1'b0, 0, 0);
    vcount = 0; hcount = 0;
    scan(0, 119, -1);
    va = vcount; na = hcount;
    repeat (15) step(1'b1, 1'b0, 0, 0);
    step(1'b1, 1'b0, 0, 0);
    vcount = 0; hcount = 0;
    scan(0, 119, -1);
    chk("stars_present", 32'(na > 0), 32'd1);
    chk("twinkle_same_set", 32'(hcount), 32'(na));
    chk("twinkle_split", 32'(va + vcount), 32'(na));

    // Dim twinkle: unlit stars appear at quarter base.
    mode = 2'd3;
    step(1'b1, 1'b0, 0, 0);
    scan(0, 119, -1);

    // Frame pulse coincident with an advance.
    mode = 2'd1;
    step(1'b1, 1'b0, 0, 0);
    scan(0, 1, -1);
    step(1'b0, 1'b1, 0, 2);
    step(1'b1, 1'b1, 1, 2);
    chk("frame_adv_seed", 32'(dut.lfsr_q), 32'(SEED));

    // Async reset mid-row while a star is on the output.
    found = 1'b0;
    for (int i = 0; i < 8000 && !found; i++) begin
      step(1'b0, 1'b1, i % W, 3 + i / W);
      if (star_valid) found = 1'b1;
    end
    chk("rst_find", 32'(found), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_colr", 32'(star_colr), 32'd0);
    chk("async_valid", 32'(star_valid), 32'd0);
    chk("async_lfsr", 32'(dut.lfsr_q), 32'(SEED));
    chk("async_night", 32'(dut.night_q), 32'd0);
    model_reset();
    @(posedge clk_pix);
    #2 rst_n = 1'b1;
    vcount = 0;
    scan(5, 20, -1);
    chk("post_rst_dark", 32'(vcount), 32'd0);

    for (int k = 1; k <= 16; k++) step(1'b1, 1'b0, 0, 0);
    chk("night_full", 32'(dut.night_q), 32'd255);
    fade_level = 8'd128;
    for (int k = 1; k <= 16; k++) begin
      step(1'b1, 1'b0, 0, 0);
      chk("night_fall", 32'(dut.night_q), (255 - 16 * k < 0) ? 32'd0 : 32'(255 - 16 * k));
    end
    vcount = 0;
    scan(0, 30, -1);
    chk("dusk_dark", 32'(vcount), 32'd0);

    fade_level = 8'd230;
    for (int k = 1; k <= 16; k++) step(1'b1, 1'b0, 0, 0);
    chk("night_full2", 32'(dut.night_q), 32'd255);
    mode = 2'd0;
    vcount = 0;
    scan(0, 30, -1);
    chk("mode_off_dark", 32'(vcount), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/star_field_gen.md
STAR_FIELD_GEN -- requirements
Module: star_field_gen

Interface
REQ-001 SHALL have parameter XW, default 10, horizontal coordinate width.
REQ-002 SHALL have parameter YW, default 9, vertical coordinate width.
REQ-003 SHALL have parameter COLRW, default 12, colour width; COLRW is a multiple of 3, and CW = COLRW/3 is the per-channel width, at most 8.
REQ-004 SHALL have parameter SKY_H, default 120, number of rows (sy < SKY_H) eligible for stars.
REQ-005 SHALL have parameter DENSITY, default 8, range 1..12, number of LFSR MSBs that must all be 1 for a star.
REQ-006 SHALL have parameter SEED, default 16'hACE1, non-zero LFSR reload value.
REQ-007 SHALL have parameter NIGHT_STEP, default 16, night-level ramp increment per frame.
REQ-008 SHALL have parameter TW_BIT, default 4, frame-counter bit that sets the twinkle period.
REQ-009 SHALL have ports: clk_pix in 1, pixel clock; rst_n in 1, reset.
REQ-010 SHALL have ports: frame in 1, single-cycle frame-start pulse; de in 1, active-pixel enable.
REQ-011 SHALL have ports: sx in XW, pixel x; sy in YW, pixel y.
REQ-012 SHALL have ports: fade_level in 8, day/night phase; mode in 2, 0 off / 1 steady / 2 twinkle / 3 twinkle-dim.
REQ-013 SHALL have ports: star_colr out COLRW, grey star colour; star_valid out 1, star pixel present.
REQ-014 SHALL use one clock, clk_pix; rst_n SHALL be asynchronous and active-low.

Function
REQ-015 SHALL hold a 16-bit Galois LFSR (mask 16'hB400): each step shifts right and XORs the mask when the outgoing LSB is 1.
REQ-016 SHALL reload the LFSR to SEED on a frame pulse, so the star pattern is identical every frame; reload SHALL take priority over an advance in the same cycle.
REQ-017 SHALL advance the LFSR exactly once per cycle with de=1 and sy<SKY_H; otherwise it holds.
REQ-018 SHALL use for each eligible pixel the LFSR state before that cycle's advance: star hit = lfsr[15:16-DENSITY] all ones.
REQ-019 SHALL keep an 8-bit frame counter, incremented on each frame pulse, wrapping 255->0.
REQ-020 SHALL define night target = 255 when fade_level<64 or fade_level>208, else 0.
REQ-021 SHALL update an 8-bit night level on each frame pulse, stepping by NIGHT_STEP toward the night target, saturating at 0 and 255 without overshoot.
REQ-022 SHALL compute base intensity = lfsr[7:0] | 8'h80 for each pixel.
REQ-023 SHALL set lit = frame_cnt[TW_BIT] XOR lfsr[8] in modes 2 and 3; lit SHALL be 1 in mode 1.
REQ-024 SHALL apply a unlit factor: mode 2 unlit -> intensity 0; mode 3 unlit -> base>>2; mode 0 -> intensity 0.
REQ-025 SHALL compute the scaled value = (intensity × night)[15:8], an 8-bit result.
REQ-026 SHALL drive each channel of star_colr with scaled[7:8-CW]; all three channels are equal.
REQ-027 SHALL run a 2-stage pipeline: stage 1 registers hit, intensity and lit; stage 2 registers the scaled colour; the output lags the pixel inputs by exactly 2 cycles.
REQ-028 SHALL drive star_valid = 1 only when the stage-2 colour is non-zero; non-star, de=0, and off-sky pixels SHALL output 0.
REQ-029 SHALL, in stage 1, use the night level and frame counter as registered before the same-cycle frame pulse.

Reset
REQ-030 SHALL, while rst_n=0, immediately force star_colr=0 and star_valid=0, clear both pipeline stages, set LFSR=SEED, night=0, frame_cnt=0.
REQ-031 SHALL, on reset release mid-frame, produce no stars until night has ramped above 0 (first frame pulse with night target 255).

Verification
REQ-032 SHALL verify: reset, then fade_level=0, mode=1, 16 frame pulses -> night =16,32,...,240,255; the 17th pulse holds 255.
REQ-033 SHALL verify: night=255, mode=1, full 640x480 frame against a reference LFSR model -> every star_colr/star_valid matches 2 cycles later, and no output occurs for sy>=SKY_H.
REQ-034 SHALL verify: de toggled 0 for 10 cycles mid-row -> LFSR holds, and the post-gap pattern equals the gapless model shifted by the gap.
REQ-035 SHALL verify: mode=2, two frames with frame_cnt[4] differing -> the lit star sets are complementary by lfsr[8]; mode=3 unlit stars output (base>>2)·255>>8.
REQ-036 SHALL verify: fade_level=128 after night=255 -> night decreases 16 per frame to 0, then all outputs are 0; mode=0 -> all outputs 0 at any night.
REQ-037 SHALL verify: frame pulse coincident with an advance, and rst_n low mid-row -> the LFSR equals SEED next cycle, and outputs go to 0 without waiting for a clock.
